// File: rtl/fp_div.sv
// ---------------------------------------------------------------------------
// fp_div
//
// IEEE 754 single-precision divider computing num1 / num2 with a multi-cycle
// restoring (shift-subtract) mantissa divider. Subnormal inputs are accepted
// and pre-normalised; subnormal results flush to signed zero. All state
// updates happen on the falling edge of clk.
//
// Ports:
//   clk      in   1   clock, state updates on falling edge
//   rst      in   1   asynchronous active-low reset
//   num1     in  32   dividend (IEEE 754 single)
//   num2     in  32   divisor  (IEEE 754 single)
//   start    in   1   sampled only in IDLE, captures num1/num2
//   num_out  out 32   quotient, valid while done=1 and held afterwards
//   done     out  1   one-cycle result-valid pulse
//   busy     out  1   high from the capture edge until done clears
//
// Optional feature:
//   FP_DIV_ROUND_EN  defined   -> round-to-nearest-even on the quotient
//                    undefined -> truncation (ROUND still costs one cycle)
// ---------------------------------------------------------------------------
module fp_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic        start,
  output logic [31:0] num_out,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PRENORM,
    S_DIVIDE,
    S_NORMALIZE,
    S_ROUND,
    S_OUTPUT
  } state_t;

  state_t state;

  // Captured operand fields
  logic        s1, s2;
  logic [7:0]  exp1_f, exp2_f;
  logic [22:0] frac1, frac2;

  // Working datapath
  logic [23:0]       m1, m2;
  logic signed [9:0] e1, e2;
  logic [24:0]       rem;
  logic [25:0]       quo;
  logic [4:0]        cnt;
  logic signed [9:0] e;
  logic [23:0]       mant;
  logic              guard, sticky;
  logic              sign;
  logic              special;
  logic [31:0]       special_res;

  // Operand classification of the captured fields
  logic a_zero, a_sub, a_inf, a_nan;
  logic b_zero, b_sub, b_inf, b_nan;

  assign a_zero = (exp1_f == 8'h00) && (frac1 == 23'd0);
  assign a_sub  = (exp1_f == 8'h00) && (frac1 != 23'd0);
  assign a_inf  = (exp1_f == 8'hFF) && (frac1 == 23'd0);
  assign a_nan  = (exp1_f == 8'hFF) && (frac1 != 23'd0);
  assign b_zero = (exp2_f == 8'h00) && (frac2 == 23'd0);
  assign b_sub  = (exp2_f == 8'h00) && (frac2 != 23'd0);
  assign b_inf  = (exp2_f == 8'hFF) && (frac2 == 23'd0);
  assign b_nan  = (exp2_f == 8'hFF) && (frac2 != 23'd0);

  // Unbiased exponents and mantissas as seen in CHECK. Subnormals use the
  // fixed exponent -126 with hidden bit 0.
  logic signed [9:0] ue1, ue2;
  logic [23:0]       cm1, cm2;

  assign ue1 = a_sub ? -10'sd126 : ($signed({2'b00, exp1_f}) - 10'sd127);
  assign ue2 = b_sub ? -10'sd126 : ($signed({2'b00, exp2_f}) - 10'sd127);
  assign cm1 = {~a_sub, frac1};
  assign cm2 = {~b_sub, frac2};

  // One pre-normalisation step. Computed ahead so the transition into DIVIDE
  // happens on the same edge that sets the last hidden bit; this keeps the
  // extra latency equal to the larger leading-zero count.
  logic [23:0]       m1_n, m2_n;
  logic signed [9:0] e1_n, e2_n;

  assign m1_n = m1[23] ? m1 : {m1[22:0], 1'b0};
  assign m2_n = m2[23] ? m2 : {m2[22:0], 1'b0};
  assign e1_n = m1[23] ? e1 : (e1 - 10'sd1);
  assign e2_n = m2[23] ? e2 : (e2 - 10'sd1);

  // Restoring divider step: trial subtraction of the divisor mantissa.
  // The remainder always stays below m2, so bit 24 is never needed after
  // a step and the shift keeps it within 25 bits.
  logic        rem_ge;
  logic [24:0] rem_diff;

  assign rem_ge   = (rem >= {1'b0, m2});
  assign rem_diff = rem - {1'b0, m2};

  // Rounding increment decision and the incremented mantissa (bit 24 is
  // the carry-out that forces renormalisation).
  logic        round_up;
  logic [24:0] mant_inc;

  assign mant_inc = {1'b0, mant} + 25'd1;

`ifdef FP_DIV_ROUND_EN
  assign round_up = guard & (sticky | mant[0]);
`else
  assign round_up = 1'b0;
`endif

  // Biased result exponent; signed so that underflow shows up as <= 0
  logic signed [9:0] biased;

  assign biased = e + 10'sd127;

  // Main controller: single sequential block carrying state, datapath and
  // registered outputs.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      num_out     <= 32'd0;
      done        <= 1'b0;
      busy        <= 1'b0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      exp1_f      <= 8'd0;
      exp2_f      <= 8'd0;
      frac1       <= 23'd0;
      frac2       <= 23'd0;
      m1          <= 24'd0;
      m2          <= 24'd0;
      e1          <= 10'sd0;
      e2          <= 10'sd0;
      rem         <= 25'd0;
      quo         <= 26'd0;
      cnt         <= 5'd0;
      e           <= 10'sd0;
      mant        <= 24'd0;
      guard       <= 1'b0;
      sticky      <= 1'b0;
      sign        <= 1'b0;
      special     <= 1'b0;
      special_res <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            s1     <= num1[31];
            exp1_f <= num1[30:23];
            frac1  <= num1[22:0];
            s2     <= num2[31];
            exp2_f <= num2[30:23];
            frac2  <= num2[22:0];
            busy   <= 1'b1;
            state  <= S_CHECK;
          end else begin
            busy <= 1'b0;
          end
        end

        S_CHECK: begin
          sign <= s1 ^ s2;
          m1   <= cm1;
          m2   <= cm2;
          e1   <= ue1;
          e2   <= ue2;
          // Special operands bypass the divider entirely
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special     <= 1'b1;
            special_res <= 32'h7FC00000;
            state       <= S_OUTPUT;
          end else if (b_zero || a_inf) begin
            special     <= 1'b1;
            special_res <= {s1 ^ s2, 8'hFF, 23'd0};
            state       <= S_OUTPUT;
          end else if (a_zero || b_inf) begin
            special     <= 1'b1;
            special_res <= {s1 ^ s2, 31'd0};
            state       <= S_OUTPUT;
          end else begin
            special <= 1'b0;
            if (cm1[23] && cm2[23]) begin
              rem   <= {1'b0, cm1};
              e     <= ue1 - ue2;
              quo   <= 26'd0;
              cnt   <= 5'd0;
              state <= S_DIVIDE;
            end else begin
              state <= S_PRENORM;
            end
          end
        end

        S_PRENORM: begin
          m1 <= m1_n;
          m2 <= m2_n;
          e1 <= e1_n;
          e2 <= e2_n;
          if (m1_n[23] && m2_n[23]) begin
            rem   <= {1'b0, m1_n};
            e     <= e1_n - e2_n;
            quo   <= 26'd0;
            cnt   <= 5'd0;
            state <= S_DIVIDE;
          end
        end

        // 26 quotient bits, MSB first; quo[25] is the integer bit
        S_DIVIDE: begin
          if (rem_ge) begin
            quo <= {quo[24:0], 1'b1};
            rem <= {rem_diff[23:0], 1'b0};
          end else begin
            quo <= {quo[24:0], 1'b0};
            rem <= {rem[23:0], 1'b0};
          end
          if (cnt == 5'd25) begin
            state <= S_NORMALIZE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        // Quotient lies in (0.5, 2); at most one left shift is needed
        S_NORMALIZE: begin
          if (quo[25]) begin
            mant   <= quo[25:2];
            guard  <= quo[1];
            sticky <= quo[0] | (rem != 25'd0);
          end else begin
            mant   <= quo[24:1];
            guard  <= quo[0];
            sticky <= (rem != 25'd0);
            e      <= e - 10'sd1;
          end
          state <= S_ROUND;
        end

        S_ROUND: begin
          if (round_up) begin
            if (mant_inc[24]) begin
              mant <= 24'h800000;
              e    <= e + 10'sd1;
            end else begin
              mant <= mant_inc[23:0];
            end
          end
          state <= S_OUTPUT;
        end

        S_OUTPUT: begin
          if (special) begin
            num_out <= special_res;
          end else if (biased >= 10'sd255) begin
            num_out <= {sign, 8'hFF, 23'd0};
          end else if (biased <= 10'sd0) begin
            num_out <= {sign, 31'd0};
          end else begin
            num_out <= {sign, biased[7:0], mant[22:0]};
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// ---------------------------------------------------------------------------
// tb_fp_div
//
// Directed self-checking bench for fp_div. Each vector is issued with a
// one-cycle start pulse; the bench counts falling edges from the capture
// edge, checking the done edge, the quotient, busy coverage and the clean
// return to idle. Also covers reset abort and back-to-back issue with start
// held high.
// ---------------------------------------------------------------------------
module tb_fp_div;

  logic        clk;
  logic        rst;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        start;
  logic [31:0] num_out;
  logic        done;
  logic        busy;

  int tests_run;
  int tests_failed;

`ifdef FP_DIV_ROUND_EN
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

  fp_div dut (
    .clk     (clk),
    .rst     (rst),
    .num1    (num1),
    .num2    (num2),
    .start   (start),
    .num_out (num_out),
    .done    (done),
    .busy    (busy)
  );

  // Free-running clock; the DUT acts on the falling edge, the bench samples
  // and drives on the rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issues one division and checks latency, result, busy and idle return.
  // Operands are scrambled right after capture to show they are not reused.
  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_q,
                               input int exp_edge);
    int   done_edge;
    logic busy_ok;
    @(posedge clk);
    num1  = a;
    num2  = b;
    start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    start     = 1'b0;
    num1      = $urandom;
    num2      = $urandom;
    busy_ok   = busy;
    done_edge = -1;
    for (int ed = 1; ed <= 80; ed++) begin
      @(negedge clk);
      @(posedge clk);
      busy_ok = busy_ok & busy;
      if (done) begin
        done_edge = ed;
        break;
      end
    end
    checkOutput({tag, "_edge"}, done_edge, exp_edge);
    checkOutput({tag, "_q"}, num_out, exp_q);
    checkOutput({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    @(posedge clk);
    checkOutput({tag, "_clr"}, {30'd0, done, busy}, 32'd0);
    checkOutput({tag, "_hold"}, num_out, exp_q);
  endtask

  initial begin
    int stray;
    int pulses;
    int edge1, edge2;
    logic [31:0] q1, q2;

    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    start = 1'b0;
    num1  = 32'd0;
    num2  = 32'd0;

    #1;
    checkOutput("reset_out", num_out, 32'd0);
    checkOutput("reset_flags", {30'd0, done, busy}, 32'd0);
    repeat (2) @(posedge clk);
    rst = 1'b1;

    // Normal operands
    applyStimulus("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 30);
    applyStimulus("one_by_three", 32'h3F800000, 32'h40400000, ONE_THIRD,    30);
    applyStimulus("neg_div",      32'hC0F00000, 32'h40200000, 32'hC0400000, 30);
    // Subnormal operands exercise PRENORM on either side
    applyStimulus("sub_num",      32'h00000001, 32'h00800000, 32'h34000000, 53);
    applyStimulus("sub_den",      32'h3F800000, 32'h00000001, 32'h7F800000, 53);
    // Special cases
    applyStimulus("x_by_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, 2);
    applyStimulus("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 2);
    applyStimulus("negzero",      32'h80000000, 32'h40000000, 32'h80000000, 2);
    applyStimulus("nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2);
    applyStimulus("inf_by_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 2);
    applyStimulus("x_by_inf",     32'h3F800000, 32'h7F800000, 32'h00000000, 2);
    applyStimulus("inf_by_x",     32'hFF800000, 32'h40000000, 32'hFF800000, 2);
    // Exponent range limits
    applyStimulus("underflow",    32'h00800000, 32'h7F000000, 32'h00000000, 30);
    applyStimulus("overflow",     32'h7F000000, 32'h3F000000, 32'h7F800000, 30);

    // Reset partway through a divide: immediate clear, no done pulse
    @(posedge clk);
    num1  = 32'h40C00000;
    num2  = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    @(posedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    @(posedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_out", num_out, 32'd0);
    checkOutput("abort_flags", {30'd0, done, busy}, 32'd0);
    repeat (2) @(posedge clk);
    rst   = 1'b1;
    stray = 0;
    for (int ed = 0; ed < 40; ed++) begin
      @(negedge clk);
      @(posedge clk);
      if (done || busy) stray++;
    end
    checkOutput("abort_no_done", stray, 0);
    applyStimulus("after_abort", 32'h3F800000, 32'h40400000, ONE_THIRD, 30);

    // start held high: one result per 31 cycles; operand change mid-run
    // must not affect the operation already captured
    @(posedge clk);
    num1  = 32'h40C00000;
    num2  = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    pulses = 0;
    edge1  = -1;
    edge2  = -1;
    q1     = 32'd0;
    q2     = 32'd0;
    for (int ed = 1; ed <= 70; ed++) begin
      @(negedge clk);
      @(posedge clk);
      if (ed == 5) begin
        num1 = 32'h3F800000;
        num2 = 32'h40400000;
      end
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          edge1 = ed;
          q1    = num_out;
        end else if (pulses == 2) begin
          edge2 = ed;
          q2    = num_out;
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b_pulses", pulses, 2);
    checkOutput("b2b_edge1", edge1, 30);
    checkOutput("b2b_q1", q1, 32'h40400000);
    checkOutput("b2b_edge2", edge2, 61);
    checkOutput("b2b_q2", q2, ONE_THIRD);
    // Let the operation captured on edge 62 drain
    for (int ed = 0; ed < 60; ed++) begin
      @(negedge clk);
      @(posedge clk);
      if (!busy) break;
    end
    checkOutput("b2b_drain", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
